// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ENQ_NONE = 2'd0,
    ENQ_ONE  = 2'd1,
    ENQ_TWO  = 2'd2
  } enq_width_t;

  // Fetch is word aligned; redirect targets drop their low two bits.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory-port, redirect and decode handshake signals of the fetch stage.
interface fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] io_if_mem_instAddr;
  logic [INST_W-1:0] io_mem_id_inst_0;
  logic [INST_W-1:0] io_mem_id_inst_1;
  logic              io_redirect_valid;
  logic [ADDR_W-1:0] io_redirect_pc;
  logic              io_dec_valid;
  logic              io_dec_ready;
  logic [INST_W-1:0] io_dec_inst;
  logic [ADDR_W-1:0] io_dec_pc;

  modport master (
    output io_if_mem_instAddr,
    input  io_mem_id_inst_0,
    input  io_mem_id_inst_1,
    input  io_redirect_valid,
    input  io_redirect_pc,
    output io_dec_valid,
    input  io_dec_ready,
    output io_dec_inst,
    output io_dec_pc
  );

  modport slave (
    input  io_if_mem_instAddr,
    output io_mem_id_inst_0,
    output io_mem_id_inst_1,
    output io_redirect_valid,
    output io_redirect_pc,
    input  io_dec_valid,
    output io_dec_ready,
    input  io_dec_inst,
    input  io_dec_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: two-wide enqueue, one-wide dequeue, synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq0,
  input  fetch_entry_t           enq0_data,
  input  logic                   enq1,
  input  fetch_entry_t           enq1_data,
  input  logic                   deq,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_slot1_s;
  logic [1:0]       enq_cnt_s;

  // Number of entries written and the slot used by the second one.
  always_comb begin
    enq_cnt_s  = {1'b0, enq0} + {1'b0, enq1};
    wr_slot1_s = wr_ptr_r + PTR_W'(enq0);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(enq_cnt_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(deq);
      count_r  <= count_r + CNT_W'(enq_cnt_s) - CNT_W'(deq);
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (!flush && enq0) begin
      mem_r[wr_ptr_r] <= enq0_data;
    end
    if (!flush && enq1) begin
      mem_r[wr_slot1_s] <= enq1_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

  fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .enq_cnt (enq_cnt_s),
    .deq     (deq),
    .count   (count_r)
  );

endmodule

// File: rtl/fetch_queue_chk.sv
// Occupancy invariants of the fetch queue.
module fetch_queue_chk #(
  parameter int DEPTH = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     flush,
  input logic [1:0]               enq_cnt,
  input logic                     deq,
  input logic [$clog2(DEPTH):0]   count
);

  // Enqueue width is chosen from the pre-dequeue space, so this bound is exact.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !flush |-> (32'(count) + 32'(enq_cnt) <= DEPTH));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    deq |-> (count != '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, two-wide fetch into a queue, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input logic      clock,
  input logic      reset,
  fetch_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_r;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  free_s;
  enq_width_t        enq_sel_s;
  logic              enq0_s;
  logic              enq1_s;
  logic              deq_s;
  logic              dec_valid_s;
  fetch_entry_t      enq0_data_s;
  fetch_entry_t      enq1_data_s;
  fetch_entry_t      head_s;
  logic [INST_W-1:0] dec_inst_s;
  logic [ADDR_W-1:0] dec_pc_s;

  // Space is judged on the registered count; a same-cycle dequeue frees nothing.
  assign free_s = CNT_W'(DEPTH) - count_s;

  // Enqueue width for this cycle; a redirect discards the fetched pair.
  always_comb begin
    enq_sel_s = ENQ_NONE;
    if (bus.io_redirect_valid) begin
      enq_sel_s = ENQ_NONE;
    end else if (free_s >= CNT_W'(32'd2)) begin
      enq_sel_s = ENQ_TWO;
    end else if (free_s == CNT_W'(32'd1)) begin
      enq_sel_s = ENQ_ONE;
    end else begin
      enq_sel_s = ENQ_NONE;
    end
  end

  // Per-slot enables and entry payloads.
  always_comb begin
    enq0_s = 1'b0;
    enq1_s = 1'b0;
    case (enq_sel_s)
      ENQ_TWO: begin
        enq0_s = 1'b1;
        enq1_s = 1'b1;
      end
      ENQ_ONE: begin
        enq0_s = 1'b1;
        enq1_s = 1'b0;
      end
      default: begin
        enq0_s = 1'b0;
        enq1_s = 1'b0;
      end
    endcase
    enq0_data_s = '{pc: pc_r,          inst: bus.io_mem_id_inst_0};
    enq1_data_s = '{pc: pc_r + 64'd4,  inst: bus.io_mem_id_inst_1};
  end

  // Fetch PC: redirect wins, otherwise advance by what was enqueued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (bus.io_redirect_valid) begin
      pc_r <= align_word(bus.io_redirect_pc);
    end else begin
      case (enq_sel_s)
        ENQ_TWO: pc_r <= pc_r + 64'd8;
        ENQ_ONE: pc_r <= pc_r + 64'd4;
        default: pc_r <= pc_r;
      endcase
    end
  end

  assign dec_valid_s = (count_s != '0);
  assign deq_s       = dec_valid_s & bus.io_dec_ready;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clock),
    .rst_n     (reset),
    .flush     (bus.io_redirect_valid),
    .enq0      (enq0_s),
    .enq0_data (enq0_data_s),
    .enq1      (enq1_s),
    .enq1_data (enq1_data_s),
    .deq       (deq_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Head is only meaningful while non-empty; show zeros otherwise.
  always_comb begin
    if (dec_valid_s) begin
      dec_inst_s = head_s.inst;
      dec_pc_s   = head_s.pc;
    end else begin
      dec_inst_s = 32'h0;
      dec_pc_s   = 64'h0;
    end
  end

  assign bus.io_if_mem_instAddr = pc_r;
  assign bus.io_dec_valid       = dec_valid_s;
  assign bus.io_dec_inst        = dec_inst_s;
  assign bus.io_dec_pc          = dec_pc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-level reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 8;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  always_comb begin
    bus.io_mem_id_inst_0 = mem_word(bus.io_if_mem_instAddr);
    bus.io_mem_id_inst_1 = mem_word(bus.io_if_mem_instAddr + 64'd4);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {pc,inst}, fetch PC, log of consumed PCs.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc = 64'h0;
  logic [63:0] m_log[$];
  logic [63:0] d_log[$];

  task automatic model_step();
    int free_v;
    free_v = DEPTH - mq.size();
    if (mq.size() != 0 && bus.io_dec_ready) begin
      m_log.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    if (bus.io_redirect_valid) begin
      mq.delete();
      m_pc = bus.io_redirect_pc & ~64'h3;
    end else if (free_v >= 2) begin
      mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
      mq.push_back('{pc: m_pc + 64'd4, inst: mem_word(m_pc + 64'd4)});
      m_pc = m_pc + 64'd8;
    end else if (free_v == 1) begin
      mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
      m_pc = m_pc + 64'd4;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mq.delete();
        m_pc = 64'h0;
      end else begin
        model_step();
      end
    end
  end

  // Record what decode actually accepted.
  initial begin
    forever begin
      @(posedge clock);
      if (bus.io_dec_valid && bus.io_dec_ready) d_log.push_back(bus.io_dec_pc);
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      chk("instAddr", bus.io_if_mem_instAddr, m_pc);
      chk("dec_valid", 64'(bus.io_dec_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("dec_pc", bus.io_dec_pc, mq[0].pc);
        chk("dec_inst", 64'(bus.io_dec_inst), 64'(mq[0].inst));
      end else begin
        chk("dec_pc_empty", bus.io_dec_pc, 64'h0);
        chk("dec_inst_empty", 64'(bus.io_dec_inst), 64'h0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    int          start_idx;
    int          n8;
    logic [39:0] pat;
    reset                 = 1'b0;
    bus.io_dec_ready      = 1'b0;
    bus.io_redirect_valid = 1'b0;
    bus.io_redirect_pc    = 64'h0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_valid", 64'(bus.io_dec_valid), 64'h0);
    chk("rst_inst", 64'(bus.io_dec_inst), 64'h0);
    chk("rst_pc", bus.io_dec_pc, 64'h0);
    chk("rst_addr", bus.io_if_mem_instAddr, 64'h0);
    #2 reset = 1'b1;
    #1;
    chk("c0_addr", bus.io_if_mem_instAddr, 64'h0);
    chk("c0_valid", 64'(bus.io_dec_valid), 64'h0);
    @(negedge clock);
    chk("c1_valid", 64'(bus.io_dec_valid), 64'h1);
    chk("c1_inst", 64'(bus.io_dec_inst), 64'h0000_C0DE);
    chk("c1_pc", bus.io_dec_pc, 64'h0);
    chk("c1_addr", bus.io_if_mem_instAddr, 64'h8);
    bus.io_dec_ready = 1'b1;
    @(negedge clock);
    chk("c2_inst", 64'(bus.io_dec_inst), 64'h0004_C0DE);
    chk("c2_pc", bus.io_dec_pc, 64'h4);
    bus.io_dec_ready = 1'b0;

    // Fill with ready low
    do_reset();
    #1 chk("fill_cnt0", 64'(dut.count_s), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("fill_cnt", 64'(dut.count_s), 64'(2 * k));
      chk("fill_addr", bus.io_if_mem_instAddr, 64'(8 * k));
    end
    repeat (10) begin
      @(negedge clock);
      chk("full_addr", bus.io_if_mem_instAddr, 64'h20);
      chk("full_cnt", 64'(dut.count_s), 64'h8);
      chk("full_head", bus.io_dec_pc, 64'h0);
    end

    // One pop from full, then a single enqueue
    bus.io_dec_ready = 1'b1;
    @(negedge clock);
    chk("pop_cnt", 64'(dut.count_s), 64'h7);
    chk("pop_head", bus.io_dec_pc, 64'h4);
    bus.io_dec_ready = 1'b0;
    @(negedge clock);
    chk("single_addr", bus.io_if_mem_instAddr, 64'h24);
    chk("single_cnt", 64'(dut.count_s), 64'h8);
    bus.io_dec_ready = 1'b1;
    repeat (7) @(negedge clock);
    chk("single_pc", bus.io_dec_pc, 64'h20);
    chk("single_inst", 64'(bus.io_dec_inst), 64'h0020_C0DE);
    bus.io_dec_ready = 1'b0;

    // Redirect with five entries queued
    do_reset();
    repeat (2) @(negedge clock);
    chk("r5_cnt4", 64'(dut.count_s), 64'h4);
    bus.io_dec_ready = 1'b1;
    @(negedge clock);
    chk("r5_cnt5", 64'(dut.count_s), 64'h5);
    chk("r5_addr", bus.io_if_mem_instAddr, 64'h18);
    bus.io_dec_ready      = 1'b0;
    bus.io_redirect_valid = 1'b1;
    bus.io_redirect_pc    = 64'h103;
    @(negedge clock);
    bus.io_redirect_valid = 1'b0;
    chk("rd_addr", bus.io_if_mem_instAddr, 64'h100);
    chk("rd_valid", 64'(bus.io_dec_valid), 64'h0);
    chk("rd_cnt", 64'(dut.count_s), 64'h0);
    @(negedge clock);
    chk("rd_valid2", 64'(bus.io_dec_valid), 64'h1);
    chk("rd_pc", bus.io_dec_pc, 64'h100);
    chk("rd_inst", 64'(bus.io_dec_inst), 64'h0100_C0DE);

    // Redirect coinciding with a handshake at pc 0x8
    do_reset();
    start_idx = d_log.size();
    bus.io_dec_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("hs_head", bus.io_dec_pc, 64'h8);
    bus.io_redirect_valid = 1'b1;
    bus.io_redirect_pc    = 64'h40;
    @(negedge clock);
    bus.io_redirect_valid = 1'b0;
    chk("hs_valid", 64'(bus.io_dec_valid), 64'h0);
    chk("hs_addr", bus.io_if_mem_instAddr, 64'h40);
    @(negedge clock);
    chk("hs_pc40", bus.io_dec_pc, 64'h40);
    n8 = 0;
    for (int i = start_idx; i < d_log.size(); i++) if (d_log[i] == 64'h8) n8++;
    chk("hs_once", 64'(n8), 64'h1);
    chk("hs_last", d_log[d_log.size() - 1], 64'h8);
    @(negedge clock);
    chk("hs_pc44", bus.io_dec_pc, 64'h44);
    bus.io_dec_ready = 1'b0;

    // Asynchronous reset mid-cycle with six entries
    do_reset();
    repeat (3) @(negedge clock);
    chk("ar_cnt6", 64'(dut.count_s), 64'h6);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.io_dec_valid), 64'h0);
    chk("ar_cnt", 64'(dut.count_s), 64'h0);
    chk("ar_addr", bus.io_if_mem_instAddr, 64'h0);
    @(negedge clock);
    #2 reset = 1'b1;

    // Mixed ready pattern with a redirect that wraps the PC
    pat = 40'hF3_5A_C7_0F_E1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus.io_dec_ready      = pat[i];
      bus.io_redirect_valid = (i == 20);
      bus.io_redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF9;
    end
    @(negedge clock);
    bus.io_redirect_valid = 1'b0;
    bus.io_dec_ready      = 1'b1;
    repeat (12) @(negedge clock);

    chk("log_size", 64'(d_log.size()), 64'(m_log.size()));
    for (int i = 0; i < d_log.size() && i < m_log.size(); i++) chk("log_pc", d_log[i], m_log[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
